// File: rtl/ff_bank_pkg.sv
// Shared encodings for the multimode flip-flop bank: mode values and
// the SR illegal-input policies.
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam int POL_HOLD = 0;
    localparam int POL_CLR  = 1;
    localparam int POL_SET  = 2;

    // Unknown policy codes fall back to hold so a bad parameter never corrupts state.
    function automatic logic sr_resolve(input logic q, input int policy);
        case (policy)
            POL_CLR: sr_resolve = 1'b0;
            POL_SET: sr_resolve = 1'b1;
            default: sr_resolve = q;
        endcase
    endfunction

endpackage

// File: rtl/ff_cell_next.sv
// Next-state logic for one flip-flop channel in any of the four modes,
// plus the SR illegal-input indication for that channel.
module ff_cell_next
    import ff_bank_pkg::*;
#(
    parameter int SR_POLICY = POL_HOLD
) (
    input  logic  q,
    input  logic  a,
    input  logic  b,
    input  mode_e mode,
    output logic  q_next,
    output logic  illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11: begin
                        q_next  = sr_resolve(q, SR_POLICY);
                        illegal = 1'b1;
                    end
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = a;
            MODE_T:  q_next = q ^ a;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH flip-flops sharing one runtime-selectable mode, with sticky
// per-channel SR illegal flags and a saturating illegal-cycle counter.
module ff_bank_multimode
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter int               SR_POLICY = 0,
    parameter logic [WIDTH-1:0] Q_INIT    = '0,
    parameter logic [1:0]       MODE_INIT = 2'b00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_we,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] illegal_flag,
    output logic             illegal_any,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] cell_next;
    logic [WIDTH-1:0] cell_illegal;
    logic [WIDTH-1:0] event_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell_next #(
            .SR_POLICY (SR_POLICY)
        ) u_cell (
            .q       (q_q[i]),
            .a       (a[i]),
            .b       (b[i]),
            .mode    (mode_e'(mode_q)),
            .q_next  (cell_next[i]),
            .illegal (cell_illegal[i])
        );
    end

    // A new event in the same cycle as err_clr wins over the clear.
    always_comb begin
        event_vec = en ? cell_illegal : '0;
        q_d       = en ? cell_next : q_q;
        mode_d    = mode_we ? mode_in : mode_q;
        flag_d    = err_clr ? event_vec : (flag_q | event_vec);
        cnt_d     = err_clr ? '0 : cnt_q;
        if (|event_vec) begin
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= Q_INIT;
            mode_q <= MODE_INIT;
            flag_q <= '0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Q            = q_q;
    assign Qbar         = ~q_q;
    assign mode         = mode_q;
    assign illegal_flag = flag_q;
    assign illegal_any  = |flag_q;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Directed, table-driven bench for ff_bank_multimode (WIDTH=4, CNT_W=2),
// with a second instance using the force-clear SR policy.
module tb_ff_bank_multimode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode_we;
    logic [1:0] mode_in;
    logic [3:0] a;
    logic [3:0] b;
    logic       err_clr;

    logic [3:0] q0, qbar0, flag0;
    logic [1:0] mode0, cnt0;
    logic       any0;
    logic [3:0] q1, qbar1, flag1;
    logic [1:0] mode1, cnt1;
    logic       any1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       mode_we;
        logic [1:0] mode_in;
        logic [3:0] a;
        logic [3:0] b;
        logic       err_clr;
        logic [3:0] exp_q;
        logic [1:0] exp_mode;
        logic [3:0] exp_flag;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ff_bank_multimode #(
        .WIDTH(4), .CNT_W(2), .SR_POLICY(0), .Q_INIT(4'h0), .MODE_INIT(2'b00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_we(mode_we), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .Q(q0), .Qbar(qbar0), .mode(mode0), .illegal_flag(flag0),
        .illegal_any(any0), .illegal_cnt(cnt0)
    );

    ff_bank_multimode #(
        .WIDTH(4), .CNT_W(2), .SR_POLICY(1), .Q_INIT(4'h0), .MODE_INIT(2'b00)
    ) dut_clr (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_we(mode_we), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .Q(q1), .Qbar(qbar1), .mode(mode1), .illegal_flag(flag1),
        .illegal_any(any1), .illegal_cnt(cnt1)
    );

    task automatic add_vec(input logic r, input logic e, input logic we, input logic [1:0] mi,
                           input logic [3:0] va, input logic [3:0] vb, input logic clr,
                           input logic [3:0] eq, input logic [1:0] em, input logic [3:0] ef,
                           input logic [1:0] ec);
        vec_t v;
        v.rst_n = r;   v.en = e;     v.mode_we = we; v.mode_in = mi;
        v.a = va;      v.b = vb;     v.err_clr = clr;
        v.exp_q = eq;  v.exp_mode = em; v.exp_flag = ef; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n   = v.rst_n;
        en      = v.en;
        mode_we = v.mode_we;
        mode_in = v.mode_in;
        a       = v.a;
        b       = v.b;
        err_clr = v.err_clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, actual, expected);
        end
    endtask

    task automatic check_main(input int step, input vec_t v);
        checkOutput("Q",            step, {4'h0, q0},    {4'h0, v.exp_q});
        checkOutput("Qbar",         step, {4'h0, qbar0}, {4'h0, ~v.exp_q});
        checkOutput("mode",         step, {6'h0, mode0}, {6'h0, v.exp_mode});
        checkOutput("illegal_flag", step, {4'h0, flag0}, {4'h0, v.exp_flag});
        checkOutput("illegal_any",  step, {7'h0, any0},  {7'h0, |v.exp_flag});
        checkOutput("illegal_cnt",  step, {6'h0, cnt0},  {6'h0, v.exp_cnt});
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; en = 1'b0; mode_we = 1'b0; mode_in = 2'b00;
        a = 4'h0; b = 4'h0; err_clr = 1'b0;

        //       rst en we mi    a     b    clr   Q     mode   flag  cnt
        add_vec(0, 1, 1, 2'd3, 4'hF, 4'h0, 1,  4'h0, 2'd0, 4'h0, 2'd0);
        add_vec(0, 1, 1, 2'd3, 4'hF, 4'h0, 1,  4'h0, 2'd0, 4'h0, 2'd0);
        add_vec(1, 1, 0, 2'd0, 4'hF, 4'h0, 0,  4'hF, 2'd0, 4'h0, 2'd0);
        add_vec(1, 1, 0, 2'd0, 4'h0, 4'h0, 0,  4'hF, 2'd0, 4'h0, 2'd0);
        add_vec(1, 1, 0, 2'd0, 4'h0, 4'h3, 0,  4'hC, 2'd0, 4'h0, 2'd0);
        add_vec(1, 1, 0, 2'd0, 4'h1, 4'h1, 0,  4'hC, 2'd0, 4'h1, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'h3, 4'h3, 0,  4'hC, 2'd0, 4'h3, 2'd2);
        add_vec(1, 1, 0, 2'd0, 4'h3, 4'h3, 0,  4'hC, 2'd0, 4'h3, 2'd3);
        add_vec(1, 1, 0, 2'd0, 4'h3, 4'h3, 0,  4'hC, 2'd0, 4'h3, 2'd3);
        add_vec(1, 1, 0, 2'd0, 4'h3, 4'h3, 0,  4'hC, 2'd0, 4'h3, 2'd3);
        add_vec(1, 1, 0, 2'd0, 4'h3, 4'h3, 0,  4'hC, 2'd0, 4'h3, 2'd3);
        add_vec(1, 1, 0, 2'd0, 4'h4, 4'h4, 1,  4'hC, 2'd0, 4'h4, 2'd1);
        add_vec(1, 1, 1, 2'd3, 4'hF, 4'h0, 0,  4'hF, 2'd3, 4'h4, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'hF, 4'h0, 0,  4'h0, 2'd3, 4'h4, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'h5, 4'h0, 0,  4'h5, 2'd3, 4'h4, 2'd1);
        add_vec(1, 1, 1, 2'd1, 4'h0, 4'h0, 0,  4'h5, 2'd1, 4'h4, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'hF, 4'hF, 0,  4'hA, 2'd1, 4'h4, 2'd1);
        add_vec(1, 1, 1, 2'd2, 4'h0, 4'h0, 0,  4'hA, 2'd2, 4'h4, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'h9, 4'hF, 0,  4'h9, 2'd2, 4'h4, 2'd1);
        add_vec(1, 0, 1, 2'd0, 4'hF, 4'hF, 0,  4'h9, 2'd0, 4'h4, 2'd1);
        add_vec(1, 0, 0, 2'd0, 4'hF, 4'hF, 0,  4'h9, 2'd0, 4'h4, 2'd1);
        add_vec(1, 0, 0, 2'd0, 4'hF, 4'hF, 1,  4'h9, 2'd0, 4'h0, 2'd0);
        add_vec(1, 1, 0, 2'd0, 4'hF, 4'hF, 0,  4'h9, 2'd0, 4'hF, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'hF, 4'h0, 0,  4'hF, 2'd0, 4'hF, 2'd1);
        add_vec(1, 1, 0, 2'd0, 4'hF, 4'hF, 0,  4'hF, 2'd0, 4'hF, 2'd2);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            check_main(i, vecs[i]);
        end

        // Mid-run reset with every strobe active must still return to the reset state.
        v = '{rst_n: 0, en: 1, mode_we: 1, mode_in: 2'd3, a: 4'hF, b: 4'hF, err_clr: 0,
              exp_q: 4'h0, exp_mode: 2'd0, exp_flag: 4'h0, exp_cnt: 2'd0};
        applyStimulus(v);
        check_main(100, v);
        checkOutput("clr_Q_reset", 100, {4'h0, q1}, 8'h00);

        v = '{rst_n: 1, en: 1, mode_we: 0, mode_in: 2'd0, a: 4'hF, b: 4'h0, err_clr: 0,
              exp_q: 4'hF, exp_mode: 2'd0, exp_flag: 4'h0, exp_cnt: 2'd0};
        applyStimulus(v);
        check_main(101, v);
        checkOutput("clr_Q_set", 101, {4'h0, q1}, 8'h0F);

        // S=R=1 everywhere: hold policy keeps F, force-clear policy drops to 0.
        v = '{rst_n: 1, en: 1, mode_we: 0, mode_in: 2'd0, a: 4'hF, b: 4'hF, err_clr: 0,
              exp_q: 4'hF, exp_mode: 2'd0, exp_flag: 4'hF, exp_cnt: 2'd1};
        applyStimulus(v);
        check_main(102, v);
        checkOutput("clr_Q_illegal",    102, {4'h0, q1},    8'h00);
        checkOutput("clr_Qbar_illegal", 102, {4'h0, qbar1}, 8'h0F);
        checkOutput("clr_flag_illegal", 102, {4'h0, flag1}, 8'h0F);
        checkOutput("clr_cnt_illegal",  102, {6'h0, cnt1},  8'h01);

        v = '{rst_n: 1, en: 1, mode_we: 0, mode_in: 2'd0, a: 4'h2, b: 4'h0, err_clr: 0,
              exp_q: 4'hF, exp_mode: 2'd0, exp_flag: 4'hF, exp_cnt: 2'd1};
        applyStimulus(v);
        check_main(103, v);
        checkOutput("clr_Q_after", 103, {4'h0, q1}, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
